boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Byte-stream program loader sitting directly upstream of the mini-MIPS core.
- Receives framed commands on a valid/ready byte interface.
- Assembles big-endian 32-bit words and writes them into instruction memory or data memory through the core's load ports (inst_addr/inst_data_in, mem_addr/mem_data_in).
- Holds the core in reset until a GO command, replacing the bench-driven preload sequence.

Parameters:
- IMEM_DEPTH, 1024: instruction memory depth in words; write addresses at or above this are out of range.
- DMEM_DEPTH, 1024: data memory depth in words; same range rule.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at posedge clk
- inst_we  out  1  one-cycle instruction-memory write strobe
- inst_addr  out  32  instruction word address, zero-extended
- inst_data_in  out  32  instruction word
- mem_we  out  1  one-cycle data-memory write strobe
- mem_addr  out  32  data word address, zero-extended
- mem_data_in  out  32  data word
- cpu_rst  out  1  active-high reset to the core; 1 while loading
- err  out  2  sticky: bit0 checksum/unknown command, bit1 address out of range
- words_written  out  16  count of committed writes since reset, wraps at 0xFFFF

Behaviour:
- Clock and reset: single clock. rst_n is asynchronous, active-low, and fixed.
- Reset values: state IDLE, rx_ready=0, inst_we=mem_we=0, all addr/data outputs 0, cpu_rst=1, err=0, words_written=0. rx_ready rises on the first clk after rst_n deasserts.
- Frame format: CMD, ADDR_HI, ADDR_LO, COUNT, then COUNT×4 data bytes MSB first, then CHK. COUNT=0 means 256 words.
- Commands:
  - 0x49 'I' targets instruction memory; 0x44 'D' targets data memory.
  - 0x47 'G' (GO): cpu_rst→0 next cycle if err==0, otherwise ignored. State becomes RUN.
  - 0x43 'C' clears err.
  - Any other byte in IDLE: discarded, err[0] set.
- States: IDLE → ADDR_HI → ADDR_LO → CNT → DATA (byte index 0..3, word counter) → CHK → IDLE.
- RUN: accepts only 0x48 'H', which sets cpu_rst=1 next cycle and returns to IDLE. All other bytes are accepted and discarded.
- rx_ready is 1 in every state after reset. The loader never back-pressures; stalls come only from rx_valid low, of any length.
- Word commit: the cycle after the 4th data byte is accepted, the selected we pulses high for exactly 1 cycle with addr and data held stable. Addr and data outputs keep their last value otherwise. The word address then increments, with 16-bit wrap 0xFFFF→0x0000.
- Range: address ≥ target DEPTH suppresses the strobe and sets err[1]; the frame continues. words_written counts committed strobes only.
- Checksum: XOR of ADDR_HI, ADDR_LO, COUNT and all data bytes. On mismatch, err[0] is set; words already written are not undone. Return to IDLE either way.
- cpu_rst stays 1 in every state except RUN.
- Reset mid-frame: partial word discarded, asynchronous return to reset values.

Optional Feature:
- Macro BOOT_LOADER_CHKSUM_EN.
- Defined: CHK byte is present and checked as above.
- Undefined: frames carry no CHK byte; the state after the last word's 4th byte is IDLE, and err[0] is set only by unknown commands.

Decomposition:
- Shared package boot_loader_pkg:
  - command byte constants CMD_INST, CMD_DATA, CMD_GO, CMD_CLR, CMD_HALT
  - state enum
  - ERR_CHK/ERR_RANGE bit indices
- One natural sub-module: boot_word_asm. It takes bytes, produces a 32-bit word plus a one-cycle word_done, and maintains the running XOR. The FSM, address counter and strobe generation stay in the top.

Test Plan:
- Instruction write: bytes 49 00 00 01 20 08 00 01 28 → inst_we high for 1 cycle, 1 clk after byte 0x01, inst_addr=0, inst_data_in=0x20080001; err=0; words_written=1.
- Data write: bytes 44 00 01 02 00 00 00 04 00 00 00 09 0E → mem_we pulses twice: (addr 1, 4) then (addr 2, 9); err=0.
- Checksum failure: I frame from first scenario with CHK=0x29 → err=01; then 47 → cpu_rst stays 1; then 43, 47 → err=00 and cpu_rst=0 one cycle after 0x47.
- Range: IMEM_DEPTH=1024; bytes 49 03 FF 02, words 0x11111111 and 0x22222222, correct CHK → one strobe at addr 0x3FF, none at 0x400; err=10; words_written=1.
- Async reset mid-frame: rst_n low after 2 data bytes → cpu_rst=1, inst_we=0, err=0 immediately. After release, the full first-scenario frame is written correctly.
- Stalls and run control: first-scenario frame with rx_valid low 5 cycles between each byte → identical write. Then 47 → cpu_rst 0; 55 → ignored; 48 → cpu_rst 1, state IDLE.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_loader_pkg
// Shared definitions for the byte-stream program loader: command byte codes,
// the loader state encoding, sticky error bit positions and a helper that
// turns a frame COUNT byte into a word count.
// ---------------------------------------------------------------------------
package boot_loader_pkg;

    localparam logic [7:0] CMD_INST = 8'h49;  // 'I' write instruction memory
    localparam logic [7:0] CMD_DATA = 8'h44;  // 'D' write data memory
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G' release the core
    localparam logic [7:0] CMD_CLR  = 8'h43;  // 'C' clear sticky errors
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H' put the core back in reset

    localparam int ERR_CHK   = 0;  // checksum mismatch or unknown command
    localparam int ERR_RANGE = 1;  // write address beyond memory depth

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT,
        ST_DATA,
        ST_CHK,
        ST_RUN
    } state_t;

    // COUNT byte of zero encodes a full 256-word frame.
    function automatic logic [8:0] frame_words(input logic [7:0] cnt);
        return (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// ---------------------------------------------------------------------------
// boot_word_asm
// Packs data bytes (MSB first) into 32-bit words and keeps the running XOR
// of every frame byte after the command byte.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   byte_in      accepted byte
//   clr          start of a new frame: restart byte index and XOR
//   hdr_en       header byte (address/count): XOR only
//   data_en      data byte: XOR and shift into the word
//   word         assembled word, valid while word_done is high
//   word_done    combinational, high with the 4th data byte of a word
//   chk          XOR of all header/data bytes accepted so far in the frame
// ---------------------------------------------------------------------------
module boot_word_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        clr,
    input  logic        hdr_en,
    input  logic        data_en,
    output logic [31:0] word,
    output logic        word_done,
    output logic [7:0]  chk
);

    logic [23:0] shift_reg;
    logic [1:0]  idx_reg;
    logic [7:0]  chk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 24'd0;
            idx_reg   <= 2'd0;
            chk_reg   <= 8'd0;
        end else if (clr) begin
            idx_reg <= 2'd0;
            chk_reg <= 8'd0;
        end else if (hdr_en || data_en) begin
            chk_reg <= chk_reg ^ byte_in;
            if (data_en) begin
                shift_reg <= {shift_reg[15:0], byte_in};
                idx_reg   <= idx_reg + 2'd1;  // wraps to 0 after the 4th byte
            end
        end
    end

    // The word is completed combinationally so the top can register the
    // write strobe on the same edge that accepts the last byte.
    assign word      = {shift_reg, byte_in};
    assign word_done = data_en && !clr && (idx_reg == 2'd3);
    assign chk       = chk_reg;

endmodule

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
// Byte-stream program loader in front of the mini-MIPS core. Decodes framed
// commands (CMD, ADDR_HI, ADDR_LO, COUNT, COUNT*4 data bytes [, CHK]) and
// writes big-endian words into instruction or data memory through the core's
// load ports. Keeps the core in reset until a GO command.
//
// Build option: BOOT_LOADER_CHKSUM_EN
//   defined   - each frame ends with a CHK byte (XOR of header and data
//               bytes); a mismatch sets err[0].
//   undefined - frames end after the last data byte; no CHK byte.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready  byte input, transfer on valid && ready
//   inst_we/inst_addr/inst_data_in  instruction memory write port
//   mem_we/mem_addr/mem_data_in     data memory write port
//   cpu_rst                    active-high core reset, low only in RUN
//   err                        sticky: [0] checksum/unknown cmd, [1] range
//   words_written              committed write count (wraps)
// ---------------------------------------------------------------------------
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        inst_we,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_data_in,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        cpu_rst,
    output logic [1:0]  err,
    output logic [15:0] words_written
);

`ifdef BOOT_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    state_t      state_reg;
    logic        target_data_reg;  // 1: data memory, 0: instruction memory
    logic [15:0] addr_reg;         // current word address within the frame
    logic [8:0]  words_left_reg;   // words still to receive, 1..256

    logic        take;
    logic        asm_clr;
    logic        asm_hdr;
    logic        asm_data;
    logic [31:0] asm_word;
    logic        asm_done;
    logic [7:0]  asm_chk;
    logic        in_range;

    assign take = rx_valid && rx_ready;

    always_comb begin
        asm_clr  = 1'b0;
        asm_hdr  = 1'b0;
        asm_data = 1'b0;
        if (take) begin
            asm_clr  = (state_reg == ST_IDLE);
            asm_hdr  = (state_reg == ST_ADDR_HI) || (state_reg == ST_ADDR_LO) ||
                       (state_reg == ST_CNT);
            asm_data = (state_reg == ST_DATA);
        end
    end

    always_comb begin
        in_range = 1'b0;
        if (target_data_reg)
            in_range = ({16'd0, addr_reg} < 32'(DMEM_DEPTH));
        else
            in_range = ({16'd0, addr_reg} < 32'(IMEM_DEPTH));
    end

    boot_word_asm u_word_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (rx_data),
        .clr       (asm_clr),
        .hdr_en    (asm_hdr),
        .data_en   (asm_data),
        .word      (asm_word),
        .word_done (asm_done),
        .chk       (asm_chk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            target_data_reg <= 1'b0;
            addr_reg        <= 16'd0;
            words_left_reg  <= 9'd0;
            rx_ready        <= 1'b0;
            inst_we         <= 1'b0;
            inst_addr       <= 32'd0;
            inst_data_in    <= 32'd0;
            mem_we          <= 1'b0;
            mem_addr        <= 32'd0;
            mem_data_in     <= 32'd0;
            cpu_rst         <= 1'b1;
            err             <= 2'b00;
            words_written   <= 16'd0;
        end else begin
            // The loader never back-pressures once out of reset.
            rx_ready <= 1'b1;
            inst_we  <= 1'b0;
            mem_we   <= 1'b0;

            // Word commit: strobe, address and data are registered together;
            // an out-of-range word only flags the error and the frame goes on.
            if (asm_done) begin
                if (in_range) begin
                    if (target_data_reg) begin
                        mem_we      <= 1'b1;
                        mem_addr    <= {16'd0, addr_reg};
                        mem_data_in <= asm_word;
                    end else begin
                        inst_we      <= 1'b1;
                        inst_addr    <= {16'd0, addr_reg};
                        inst_data_in <= asm_word;
                    end
                    words_written <= words_written + 16'd1;
                end else begin
                    err[ERR_RANGE] <= 1'b1;
                end
                addr_reg <= addr_reg + 16'd1;
            end

            if (take) begin
                case (state_reg)
                    ST_IDLE: begin
                        case (rx_data)
                            CMD_INST: begin
                                target_data_reg <= 1'b0;
                                state_reg       <= ST_ADDR_HI;
                            end
                            CMD_DATA: begin
                                target_data_reg <= 1'b1;
                                state_reg       <= ST_ADDR_HI;
                            end
                            CMD_GO: begin
                                // GO is dropped entirely while any error is pending.
                                if (err == 2'b00) begin
                                    cpu_rst   <= 1'b0;
                                    state_reg <= ST_RUN;
                                end
                            end
                            CMD_CLR:  err <= 2'b00;
                            default:  err[ERR_CHK] <= 1'b1;
                        endcase
                    end
                    ST_ADDR_HI: begin
                        addr_reg[15:8] <= rx_data;
                        state_reg      <= ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        addr_reg[7:0] <= rx_data;
                        state_reg     <= ST_CNT;
                    end
                    ST_CNT: begin
                        words_left_reg <= frame_words(rx_data);
                        state_reg      <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (asm_done) begin
                            if (words_left_reg == 9'd1)
                                state_reg <= CHK_EN ? ST_CHK : ST_IDLE;
                            else
                                words_left_reg <= words_left_reg - 9'd1;
                        end
                    end
                    ST_CHK: begin
                        if (rx_data != asm_chk)
                            err[ERR_CHK] <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (rx_data == CMD_HALT) begin
                            cpu_rst   <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_loader
// Directed scenarios followed by randomized frames and commands. Expected
// memory writes go into a scoreboard queue as frames are issued; a monitor
// process pops and compares each observed write strobe. Status (err,
// words_written, cpu_rst) is compared against a frame-level reference model.
// Follows the BOOT_LOADER_CHKSUM_EN setting of the build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_boot_loader;

    localparam int IMEM_D = 1024;
    localparam int DMEM_D = 512;
`ifdef BOOT_LOADER_CHKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        inst_we;
    logic [31:0] inst_addr;
    logic [31:0] inst_data_in;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        cpu_rst;
    logic [1:0]  err;
    logic [15:0] words_written;

    boot_loader #(.IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .inst_we       (inst_we),
        .inst_addr     (inst_addr),
        .inst_data_in  (inst_data_in),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .cpu_rst       (cpu_rst),
        .err           (err),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        tgt;   // 1: data memory
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    // Reference model state
    logic [1:0]  m_err;
    logic        m_cpu_rst;
    logic [15:0] m_ww;
    bit          m_run;
    logic [31:0] fw [0:255];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int stall);
        rx_valid = 1'b0;
        repeat (stall) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        check32("rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic tgt, input logic [15:0] base, input logic [7:0] cnt,
                              input bit corrupt, input int smin, input int smax);
        int          n;
        int          depth;
        logic [15:0] a;
        logic [7:0]  cs;
        logic [7:0]  b;
        bit          inr;
        n     = (cnt == 8'd0) ? 256 : int'(cnt);
        depth = tgt ? DMEM_D : IMEM_D;
        cs    = base[15:8] ^ base[7:0] ^ cnt;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            if (int'(a) < depth) begin
                exp_q.push_back('{tgt: tgt, addr: {16'd0, a}, data: fw[i]});
                m_ww = m_ww + 16'd1;
            end else begin
                m_err[1] = 1'b1;
            end
        end
        $display("frame %s base=%h cnt=%0d corrupt=%0d", tgt ? "D" : "I", base, n, corrupt);
        send_byte(tgt ? 8'h44 : 8'h49, $urandom_range(smin, smax));
        send_byte(base[15:8], $urandom_range(smin, smax));
        send_byte(base[7:0], $urandom_range(smin, smax));
        send_byte(cnt, $urandom_range(smin, smax));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b  = fw[i][31 - 8*k -: 8];
                cs = cs ^ b;
                send_byte(b, $urandom_range(smin, smax));
            end
            a   = base + 16'(i);
            inr = int'(a) < depth;
            // The strobe must be up exactly one cycle after the 4th byte.
            check32("strobe_latency", {31'd0, tgt ? mem_we : inst_we}, {31'd0, inr});
        end
        if (CHK_ON) begin
            if (corrupt) begin
                cs = cs ^ 8'($urandom_range(1, 255));
                m_err[0] = 1'b1;
            end
            send_byte(cs, $urandom_range(smin, smax));
        end
    endtask

    task automatic cmd_byte(input logic [7:0] b);
        if (!m_run) begin
            case (b)
                8'h47: if (m_err == 2'b00) begin m_run = 1; m_cpu_rst = 1'b0; end
                8'h43: m_err = 2'b00;
                default: m_err[0] = 1'b1;
            endcase
        end else if (b == 8'h48) begin
            m_run = 0;
            m_cpu_rst = 1'b1;
        end
        $display("cmd %h run=%0d err=%b", b, m_run, m_err);
        send_byte(b, $urandom_range(0, 2));
        check32("cmd_cpu_rst", {31'd0, cpu_rst}, {31'd0, m_cpu_rst});
        check32("cmd_err", {30'd0, err}, {30'd0, m_err});
    endtask

    task automatic check_status(input string name);
        @(negedge clk);
        $display("status %s err=%b ww=%0d cpu_rst=%b", name, err, words_written, cpu_rst);
        check32({name, "_err"}, {30'd0, err}, {30'd0, m_err});
        check32({name, "_ww"}, {16'd0, words_written}, {16'd0, m_ww});
        check32({name, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, m_cpu_rst});
    endtask

    function automatic logic [7:0] rand_unknown();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h49 || b == 8'h44 || b == 8'h47 || b == 8'h43);
        return b;
    endfunction

    // Scoreboard monitor: compares every observed write strobe.
    initial begin
        wr_t  e;
        logic prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (inst_we || mem_we) begin
                check32("we_exclusive", {31'd0, inst_we && mem_we}, 32'd0);
                check32("we_one_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: inst_we=%b mem_we=%b with empty scoreboard", inst_we, mem_we);
                end else begin
                    e = exp_q.pop_front();
                    $display("write %s addr=%h data=%h", mem_we ? "D" : "I",
                             mem_we ? mem_addr : inst_addr, mem_we ? mem_data_in : inst_data_in);
                    check32("wr_target", {31'd0, mem_we}, {31'd0, e.tgt});
                    check32("wr_addr", mem_we ? mem_addr : inst_addr, e.addr);
                    check32("wr_data", mem_we ? mem_data_in : inst_data_in, e.data);
                end
            end
            prev_we = inst_we || mem_we;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        int n;
        logic [15:0] base;
        logic [7:0]  cnt;

        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        m_err = 2'b00;
        m_cpu_rst = 1'b1;
        m_ww = 16'd0;
        m_run = 0;
        repeat (3) @(negedge clk);
        check32("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check32("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check32("rst_we", {30'd0, inst_we, mem_we}, 32'd0);
        check32("rst_inst_addr", inst_addr, 32'd0);
        check32("rst_inst_data", inst_data_in, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_mem_data", mem_data_in, 32'd0);
        check32("rst_err", {30'd0, err}, 32'd0);
        check32("rst_ww", {16'd0, words_written}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check32("ready_after_rst", {31'd0, rx_ready}, 32'd1);

        // Instruction write
        fw[0] = 32'h20080001;
        send_frame(1'b0, 16'h0000, 8'd1, 0, 0, 0);
        check_status("inst_write");

        // Data write, two words
        fw[0] = 32'h00000004;
        fw[1] = 32'h00000009;
        send_frame(1'b1, 16'h0001, 8'd2, 0, 0, 1);
        check_status("data_write");

        // Range: second word falls off the end of instruction memory
        fw[0] = 32'h11111111;
        fw[1] = 32'h22222222;
        send_frame(1'b0, 16'h03FF, 8'd2, 0, 0, 1);
        check_status("range");

        // Error gating of GO
        cmd_byte(8'h43);
        fw[0] = 32'h20080001;
        if (CHK_ON) send_frame(1'b0, 16'h0000, 8'd1, 1, 0, 0);
        else        cmd_byte(8'h5A);
        check_status("chk_fail");
        cmd_byte(8'h47);
        check_status("go_blocked");
        cmd_byte(8'h43);
        cmd_byte(8'h47);
        cmd_byte(8'h55);
        cmd_byte(8'h48);
        check_status("run_halt");

        // Asynchronous reset in the middle of a frame
        cmd_byte(8'h5A);
        send_byte(8'h49, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-frame");
        check32("arst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check32("arst_inst_we", {31'd0, inst_we}, 32'd0);
        check32("arst_err", {30'd0, err}, 32'd0);
        check32("arst_ww", {16'd0, words_written}, 32'd0);
        check32("arst_inst_addr", inst_addr, 32'd0);
        m_err = 2'b00;
        m_cpu_rst = 1'b1;
        m_ww = 16'd0;
        m_run = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fw[0] = 32'h20080001;
        send_frame(1'b0, 16'h0000, 8'd1, 0, 0, 0);
        check_status("after_arst");

        // Same frame with five idle cycles before every byte, then run control
        send_frame(1'b0, 16'h0000, 8'd1, 0, 5, 5);
        check_status("stalled");
        cmd_byte(8'h47);
        cmd_byte(8'h55);
        cmd_byte(8'h48);
        check_status("stall_run");

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            sel = (it == 0) ? 0 : int'($urandom_range(0, 9));
            if (sel <= 5) begin
                case ($urandom_range(0, 3))
                    0: base = 16'(IMEM_D - 2);
                    1: base = 16'hFFFE;
                    2: base = 16'(DMEM_D - 1);
                    default: base = 16'($urandom_range(0, 300));
                endcase
                cnt = (it == 0) ? 8'd0 : 8'($urandom_range(1, 4));
                n = (cnt == 8'd0) ? 256 : int'(cnt);
                for (int i = 0; i < n; i++) fw[i] = $urandom;
                send_frame(1'($urandom_range(0, 1)), base, cnt,
                           CHK_ON && ($urandom_range(0, 4) == 0), 0, (it == 0) ? 0 : 2);
            end else if (sel == 6 || sel == 9) begin
                cmd_byte(8'h43);
            end else if (sel == 7) begin
                cmd_byte(rand_unknown());
            end else begin
                cmd_byte(8'h47);
                if (m_run) begin
                    for (int j = 0; j < 3; j++) begin
                        logic [7:0] r;
                        do r = 8'($urandom_range(0, 255)); while (r == 8'h48);
                        cmd_byte(r);
                    end
                    cmd_byte(8'h48);
                end
            end
            check_status("random");
        end

        repeat (3) @(negedge clk);
        check32("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
